// File: rtl/lfsr_run_sequencer.sv
// lfsr_run_sequencer
// Start-triggered job engine for the 8-bit pattern generator:
//   - latches tap configuration, seed, step count and base address;
//   - steps the LFSR num_steps times;
//   - writes every new pattern to data memory over a req/ack port;
//   - reports the per-step Hamming distance and its truncated average.
//
// Optional build macro HD_LOG_EN:
//   - Each step issues a second write of {4'b0,hd}.
//   - That write goes to the pattern address with its MSB flipped.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, abort          job start (sampled in IDLE), job cancel
//   tap_cfg, seed         tap enables and initial LFSR value
//   num_steps, base_addr  step count and first write address
//   mem_we/addr/wdata     write request, held until mem_ack
//   mem_ack               write accepted this cycle
//   lfsr_q, hd, hd_avg    current pattern, last step HD, average HD
//   busy, done            not-IDLE flag, one-cycle completion pulse
module lfsr_run_sequencer #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8,
    parameter int TOT_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [6:0]        tap_cfg,
    input  logic [7:0]        seed,
    input  logic [CNT_W-1:0]  num_steps,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    output logic [7:0]        lfsr_q,
    output logic [3:0]        hd,
    output logic [7:0]        hd_avg,
    output logic              busy,
    output logic              done
);

    localparam int DCNT_W = $clog2(TOT_W);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(TOT_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_MSB  = {1'b1, {(ADDR_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, STEP, WRITE, DIV, DONE} state_t;

    state_t state, state_nx;

    logic [6:0]        tap_l;
    logic [7:0]        seed_l;
    logic [CNT_W-1:0]  steps_l;
    logic [ADDR_W-1:0] base_l;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr;
    logic [TOT_W-1:0]  total;
    logic [TOT_W-1:0]  quo;
    logic [CNT_W-1:0]  rem;
    logic [DCNT_W-1:0] dcnt;

    logic [7:0]        lfsr_nx;
    logic [3:0]        step_hd;
    logic [CNT_W:0]    rem_sh;
    logic              rem_ge;
    logic [CNT_W-1:0]  rem_nx;
    logic [TOT_W-1:0]  quo_nx;
    logic              last_wr;

`ifdef HD_LOG_EN
    logic              wr_hd;   // second (HD log) write of the current step
`endif

    // Galois-style shift left: the bit leaving q[7] re-enters at q[0] and
    // toggles q[i] (i=1..7) where tap_cfg[7-i] is set.
    always_comb begin
        lfsr_nx = {lfsr_q[6:0], lfsr_q[7]}
                ^ ({tap_l[0], tap_l[1], tap_l[2], tap_l[3],
                    tap_l[4], tap_l[5], tap_l[6], 1'b0} & {8{lfsr_q[7]}});
        step_hd = 4'($countones(lfsr_q ^ lfsr_nx));
    end

    // One restoring-division iteration per cycle; the dividend is shifted
    // out of quo while quotient bits are shifted in.
    always_comb begin
        rem_sh = {rem, quo[TOT_W-1]};
        rem_ge = (rem_sh >= {1'b0, steps_l});
        rem_nx = rem_ge ? CNT_W'(rem_sh - {1'b0, steps_l}) : rem_sh[CNT_W-1:0];
        quo_nx = {quo[TOT_W-2:0], rem_ge};
    end

    always_comb begin
`ifdef HD_LOG_EN
        last_wr = wr_hd;
`else
        last_wr = 1'b1;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = LOAD;
            LOAD:  state_nx = (steps_l == '0) ? DONE : STEP;
            STEP:  state_nx = WRITE;
            WRITE: if (mem_ack && last_wr) state_nx = (cnt < steps_l) ? STEP : DIV;
            DIV:   if (dcnt == DCNT_LAST) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort)
            state_nx = IDLE;
    end

    // Datapath registers; abort freezes everything except write accounting
    always_ff @(posedge clk) begin
        if (reset) begin
            tap_l   <= '0;
            seed_l  <= '0;
            steps_l <= '0;
            base_l  <= '0;
            cnt     <= '0;
            addr    <= '0;
            total   <= '0;
            quo     <= '0;
            rem     <= '0;
            dcnt    <= '0;
            lfsr_q  <= '0;
            hd      <= '0;
            hd_avg  <= '0;
`ifdef HD_LOG_EN
            wr_hd   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        tap_l   <= tap_cfg;
                        seed_l  <= seed;
                        steps_l <= num_steps;
                        base_l  <= base_addr;
                    end
                end
                LOAD: begin
                    if (!abort) begin
                        lfsr_q <= seed_l;
                        addr   <= base_l;
                        cnt    <= '0;
                        total  <= '0;
                        hd     <= '0;
`ifdef HD_LOG_EN
                        wr_hd  <= 1'b0;
`endif
                        if (steps_l == '0)
                            hd_avg <= '0;
                    end
                end
                STEP: begin
                    if (!abort) begin
                        lfsr_q <= lfsr_nx;
                        hd     <= step_hd;
                        total  <= total + TOT_W'(step_hd);
                        cnt    <= cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
`ifdef HD_LOG_EN
                        wr_hd <= ~wr_hd;
                        if (wr_hd)
                            addr <= addr + 1'b1;
`else
                        addr <= addr + 1'b1;
`endif
                        if (last_wr) begin
                            quo  <= total;
                            rem  <= '0;
                            dcnt <= '0;
                        end
                    end
                end
                DIV: begin
                    if (!abort) begin
                        quo  <= quo_nx;
                        rem  <= rem_nx;
                        dcnt <= dcnt + 1'b1;
                        if (dcnt == DCNT_LAST)
                            hd_avg <= quo_nx[7:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == WRITE) begin
            mem_we    = 1'b1;
            mem_addr  = addr;
            mem_wdata = lfsr_q;
`ifdef HD_LOG_EN
            if (wr_hd) begin
                mem_addr  = addr ^ ADDR_MSB;
                mem_wdata = {4'b0, hd};
            end
`endif
        end
    end

endmodule
